// File: rtl/difftest_commit_squash.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : difftest_commit_squash
// Description : One-entry holding buffer in front of the DifftestInstrCommit
//               bridge. Merges runs of squashable commits into one record
//               whose nFused carries the merged count; emits on displacement,
//               idle timeout or flush.
// Revision    : 1.0 - initial release
// ============================================================================
module difftest_commit_squash #(
  parameter int MAX_FUSE   = 32,
  parameter int TIMEOUT    = 16,
  parameter int CORE_ID    = 0,
  parameter int PORT_INDEX = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_skip,
  input  logic        in_isRVC,
  input  logic        in_rfwen,
  input  logic        in_fpwen,
  input  logic        in_vecwen,
  input  logic        in_v0wen,
  input  logic        in_isLoad,
  input  logic        in_isStore,
  input  logic [7:0]  in_wpdest,
  input  logic [7:0]  in_wdest,
  input  logic [7:0]  in_nFused,
  input  logic [7:0]  in_special,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic [9:0]  in_robIdx,
  input  logic [6:0]  in_lqIdx,
  input  logic [6:0]  in_sqIdx,
  input  logic        in_flush,
  output logic        out_enable,
  output logic        out_skip,
  output logic        out_isRVC,
  output logic        out_rfwen,
  output logic        out_fpwen,
  output logic        out_vecwen,
  output logic        out_v0wen,
  output logic        out_isLoad,
  output logic        out_isStore,
  output logic [7:0]  out_wpdest,
  output logic [7:0]  out_wdest,
  output logic [7:0]  out_nFused,
  output logic [7:0]  out_special,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic [9:0]  out_robIdx,
  output logic [6:0]  out_lqIdx,
  output logic [6:0]  out_sqIdx,
  output logic [7:0]  out_coreid,
  output logic [7:0]  out_index
);

  localparam logic [8:0] MAX_FUSE_W = 9'(MAX_FUSE);
  localparam logic [8:0] TIMEOUT_W  = 9'(TIMEOUT);
  localparam logic       FUSE_ON    = (MAX_FUSE > 1);

  // Holding register: status plus a copy of the last absorbed record
  logic        hv;
  logic        hs;
  logic [7:0]  hc;
  logic [7:0]  idle;
  logic        h_skip, h_isRVC, h_rfwen, h_fpwen, h_vecwen, h_v0wen;
  logic        h_isLoad, h_isStore;
  logic [7:0]  h_wpdest, h_wdest, h_special;
  logic [63:0] h_pc;
  logic [31:0] h_instr;
  logic [9:0]  h_robIdx;
  logic [6:0]  h_lqIdx, h_sqIdx;

  logic        in_squashable;
  logic [8:0]  fuse_sum;
  logic [8:0]  idle_inc;
  logic        mergeable;
  logic        hold_expire;
  logic        emit;

  // Merge/emit decisions; sums are 9 bits wide so they never wrap
  always_comb begin
    in_squashable = !in_skip && (in_special == 8'd0) && !in_isLoad && !in_isStore && FUSE_ON;
    fuse_sum      = {1'b0, hc} + {1'b0, in_nFused} + 9'd1;
    idle_inc      = {1'b0, idle} + 9'd1;
    mergeable     = hv && hs && in_squashable && !in_flush && (fuse_sum < MAX_FUSE_W);
    hold_expire   = in_flush || !hs || (idle_inc >= TIMEOUT_W);
    emit          = in_valid ? (hv && !mergeable) : (hv && hold_expire);
  end

  // Holding register update: every valid input is absorbed (merge or fresh load)
  always_ff @(posedge clock) begin
    if (reset) begin
      hv        <= 1'b0;
      hs        <= 1'b0;
      hc        <= 8'd0;
      idle      <= 8'd0;
      h_skip    <= 1'b0;
      h_isRVC   <= 1'b0;
      h_rfwen   <= 1'b0;
      h_fpwen   <= 1'b0;
      h_vecwen  <= 1'b0;
      h_v0wen   <= 1'b0;
      h_isLoad  <= 1'b0;
      h_isStore <= 1'b0;
      h_wpdest  <= 8'd0;
      h_wdest   <= 8'd0;
      h_special <= 8'd0;
      h_pc      <= 64'd0;
      h_instr   <= 32'd0;
      h_robIdx  <= 10'd0;
      h_lqIdx   <= 7'd0;
      h_sqIdx   <= 7'd0;
    end else if (in_valid) begin
      hv        <= 1'b1;
      hs        <= in_squashable;
      hc        <= mergeable ? fuse_sum[7:0] : in_nFused;
      idle      <= 8'd0;
      h_skip    <= in_skip;
      h_isRVC   <= in_isRVC;
      h_rfwen   <= in_rfwen;
      h_fpwen   <= in_fpwen;
      h_vecwen  <= in_vecwen;
      h_v0wen   <= in_v0wen;
      h_isLoad  <= in_isLoad;
      h_isStore <= in_isStore;
      h_wpdest  <= in_wpdest;
      h_wdest   <= in_wdest;
      h_special <= in_special;
      h_pc      <= in_pc;
      h_instr   <= in_instr;
      h_robIdx  <= in_robIdx;
      h_lqIdx   <= in_lqIdx;
      h_sqIdx   <= in_sqIdx;
    end else if (hv) begin
      if (hold_expire) begin
        hv   <= 1'b0;
        idle <= 8'd0;
      end else if (idle != 8'hFF) begin
        idle <= idle + 8'd1;
      end
    end
  end

  // Output register: one-cycle enable pulse, fields hold between emits
  always_ff @(posedge clock) begin
    if (reset) begin
      out_enable  <= 1'b0;
      out_skip    <= 1'b0;
      out_isRVC   <= 1'b0;
      out_rfwen   <= 1'b0;
      out_fpwen   <= 1'b0;
      out_vecwen  <= 1'b0;
      out_v0wen   <= 1'b0;
      out_isLoad  <= 1'b0;
      out_isStore <= 1'b0;
      out_wpdest  <= 8'd0;
      out_wdest   <= 8'd0;
      out_nFused  <= 8'd0;
      out_special <= 8'd0;
      out_pc      <= 64'd0;
      out_instr   <= 32'd0;
      out_robIdx  <= 10'd0;
      out_lqIdx   <= 7'd0;
      out_sqIdx   <= 7'd0;
    end else begin
      out_enable <= emit;
      if (emit) begin
        out_skip    <= h_skip;
        out_isRVC   <= h_isRVC;
        out_rfwen   <= h_rfwen;
        out_fpwen   <= h_fpwen;
        out_vecwen  <= h_vecwen;
        out_v0wen   <= h_v0wen;
        out_isLoad  <= h_isLoad;
        out_isStore <= h_isStore;
        out_wpdest  <= h_wpdest;
        out_wdest   <= h_wdest;
        out_nFused  <= hc;
        out_special <= h_special;
        out_pc      <= h_pc;
        out_instr   <= h_instr;
        out_robIdx  <= h_robIdx;
        out_lqIdx   <= h_lqIdx;
        out_sqIdx   <= h_sqIdx;
      end
    end
  end

  assign out_coreid = 8'(CORE_ID);
  assign out_index  = 8'(PORT_INDEX);

endmodule
`default_nettype wire
